// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field input, memory write and status bundle for instr_encoder
interface instr_encoder_if #(
    parameter int DEPTH = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_op;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [4:0]    in_shamt;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          mem_we;
    logic          mem_ack;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [CW-1:0] count;
    logic          full;
    logic          err;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
        output mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
        input  mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs R/I/J instruction fields into words and writes them to instruction memory
module instr_encoder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h00400000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    instr_encoder_if.slave bus
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FULL
    } state_t;

    state_t        state;
    logic [CW-1:0] countReg;
    logic          errReg;
    logic          fullReg;
    logic          readyReg;
    logic          memWe;
    logic [31:0]   wdataReg;

    logic          isLegal;
    logic [31:0]   encWord;
    logic [CW-1:0] countNext;

    always_comb begin
        isLegal = 1'b0;
        encWord = 32'h0;
        case (bus.in_op)
            6'h00: begin
                isLegal = 1'b1;
                encWord = {6'b0, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
            end
            6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05: begin
                isLegal = 1'b1;
                encWord = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_imm};
            end
            6'h02, 6'h03: begin
                isLegal = 1'b1;
                encWord = {bus.in_op, bus.in_target};
            end
            default: begin
                isLegal = 1'b0;
                encWord = 32'h0;
            end
        endcase
    end

    assign countNext = countReg + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            countReg <= '0;
            errReg   <= 1'b0;
            fullReg  <= 1'b0;
            readyReg <= 1'b1;
            memWe    <= 1'b0;
            wdataReg <= 32'h0;
        end else if (clr) begin
            // Abandons any pending write; the input offered this cycle is dropped.
            state    <= IDLE;
            countReg <= '0;
            errReg   <= 1'b0;
            fullReg  <= 1'b0;
            readyReg <= 1'b1;
            memWe    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (isLegal) begin
                            wdataReg <= encWord;
                            memWe    <= 1'b1;
                            readyReg <= 1'b0;
                            state    <= WRITE;
                        end else begin
                            errReg <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        countReg <= countNext;
                        memWe    <= 1'b0;
                        if (countNext == DEPTH_C) begin
                            state    <= FULL;
                            fullReg  <= 1'b1;
                            readyReg <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            readyReg <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    memWe    <= 1'b0;
                    readyReg <= 1'b0;
                    fullReg  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    memWe    <= 1'b0;
                    readyReg <= 1'b1;
                end
            endcase
        end
    end

    // Address wraps naturally in 32 bits.
    assign bus.mem_addr  = BASE_ADDR + (32'(countReg) << 2);
    assign bus.mem_we    = memWe;
    assign bus.mem_wdata = wdataReg;
    assign bus.in_ready  = readyReg;
    assign bus.count     = countReg;
    assign bus.full      = fullReg;
    assign bus.err       = errReg;
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit words in the target instruction memory.
REQ-002 Parameter: BASE_ADDR, 32'h00400000, byte address of the first written word.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: clr  input  1  synchronous clear of word count and error flag.
REQ-006 Port: in_valid  input  1  instruction fields presented.
REQ-007 Port: in_ready  output  1  encoder accepts fields this cycle.
REQ-008 Port: in_op  input  6  opcode.
REQ-009 Port: in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-010 Port: in_funct  input  6  R-type function code.
REQ-011 Port: in_imm  input  16  I-type immediate.
REQ-012 Port: in_target  input  26  J-type target.
REQ-013 Port: mem_we  output  1  write request to instruction memory.
REQ-014 Port: mem_ack  input  1  memory accepted the write this cycle.
REQ-015 Port: mem_addr  output  32  byte address, BASE_ADDR + 4*count.
REQ-016 Port: mem_wdata  output  32  encoded instruction word.
REQ-017 Port: count  output  $clog2(DEPTH)+1  number of words written.
REQ-018 Port: full  output  1  count equals DEPTH.
REQ-019 Port: err  output  1  sticky illegal-opcode flag.

Function
REQ-020 States SHALL be IDLE, WRITE and FULL.
REQ-021 in_ready SHALL be 1 only in IDLE.
REQ-022 Legal opcodes SHALL be 00 (R), 08, 0C, 0D, 0F, 23, 2B, 04, 05 (I), 02, 03 (J) hex; all others are illegal.
REQ-023 R-type encoding SHALL be {6'b0, rs, rt, rd, shamt, funct}.
REQ-024 I-type encoding SHALL be {op, rs, rt, imm}; rd, shamt and funct are ignored.
REQ-025 J-type encoding SHALL be {op, target}; all other fields are ignored.
REQ-026 A legal accept (in_valid & in_ready) SHALL register the encoded word into mem_wdata and enter WRITE on the next edge; latency from accept to mem_we=1 is 1 cycle.
REQ-027 In WRITE, mem_we SHALL be 1 and mem_addr and mem_wdata SHALL hold stable until the cycle mem_ack=1.
REQ-028 On mem_ack in WRITE, count SHALL increment; the next state SHALL be FULL if the new count equals DEPTH, otherwise IDLE.
REQ-029 mem_ack outside WRITE SHALL be ignored.
REQ-030 An illegal accept SHALL set err=1, leave count unchanged, generate no write, and keep the block in IDLE.
REQ-031 In FULL, mem_we=0, in_ready=0 and full=1 SHALL hold until clr or reset.
REQ-032 clr SHALL have priority in every state: on the next edge state=IDLE, count=0, err=0 and mem_we=0, and any pending write is abandoned.
REQ-033 clr together with in_valid in IDLE SHALL drop the input; nothing is accepted.
REQ-034 mem_addr SHALL be computed mod 2^32 (no overflow flag).

Reset
REQ-035 Asserting reset SHALL immediately force state=IDLE, count=0, err=0, mem_we=0, mem_wdata=0 and full=0; mem_addr then equals BASE_ADDR.
REQ-036 Reset during WRITE SHALL abandon the write with no count increment.

Verification
REQ-037 Reset, then op=08, rs=0, rt=8, imm=5 -> one cycle later mem_we=1, mem_addr=32'h00400000, mem_wdata=32'h20080005; with mem_ack=1, count=1.
REQ-038 op=00, rs=8, rt=9, rd=10, shamt=0, funct=20h -> mem_wdata=32'h01095020 at mem_addr=32'h00400004.
REQ-039 op=02, target=26'h0100000 -> mem_wdata=32'h08100000; op=3F -> err=1, no mem_we, count unchanged.
REQ-040 mem_ack held 0 for 3 cycles in WRITE -> mem_we, mem_addr and mem_wdata stable and in_ready=0; ack in cycle 4 -> IDLE.
REQ-041 With DEPTH=4, write 4 legal words -> full=1 and in_ready=0; a fifth in_valid is not accepted; clr -> count=0, full=0, mem_addr=BASE_ADDR.
REQ-042 Assert reset mid-WRITE (mem_ack=0) -> mem_we=0 at once, count=0, err=0 on release.
